// File: rtl/watch_pkg.sv
// ============================================================================
// Module      : watch_pkg
// Description : Shared state encoding for the watch control unit. The display
//               logic imports the same encoding to pick which field blinks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package watch_pkg;

  // Set-mode state; the encoding is also the o_set_sel value seen by the display.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_e;

  // Mode button cycles RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  function automatic state_e next_mode(input state_e s);
    case (s)
      RUN:      return SET_HOUR;
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_SEC;
      default:  return RUN;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_repeat.sv
// ============================================================================
// Module      : btn_repeat
// Description : Up-button edge detector with auto-repeat. One registered pulse
//               on each accepted press, another DELAY cycles later, then one
//               every PERIOD cycles while the button stays held. 'clear' drops
//               the current press; the button must then be released and
//               pressed again before any further pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_repeat #(
  parameter int DELAY  = 50_000_000,
  parameter int PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic level,
  output logic pulse
);

  localparam int CNT_MAX = (DELAY > PERIOD) ? DELAY : PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] C_DELAY  = CW'(DELAY);
  localparam logic [CW-1:0] C_PERIOD = CW'(PERIOD);
  localparam logic [CW-1:0] C_TOP    = CW'(CNT_MAX);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  logic          prev_q,  prev_d;
  logic          armed_q, armed_d;   // a press was accepted and is still held
  logic          rpt_q,   rpt_d;     // past the first repeat, now on PERIOD
  logic [CW-1:0] cnt_q,   cnt_d;     // cycles since the last pulse was issued
  logic          pulse_q, pulse_d;
  logic          up_edge;

  assign up_edge = level & ~prev_q;
  assign pulse   = pulse_q;

  // Next-state: clear/release dominate, then a fresh edge, then repeat timing.
  always_comb begin
    prev_d  = level;
    armed_d = armed_q;
    rpt_d   = rpt_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (clear || !level) begin
      armed_d = 1'b0;
      rpt_d   = 1'b0;
      cnt_d   = '0;
    end else if (up_edge) begin
      armed_d = 1'b1;
      rpt_d   = 1'b0;
      cnt_d   = C_ONE;
      pulse_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == (rpt_q ? C_PERIOD : C_DELAY)) begin
        pulse_d = 1'b1;
        rpt_d   = 1'b1;
        cnt_d   = C_ONE;
      end else if (cnt_q != C_TOP) begin
        cnt_d = cnt_q + C_ONE;
      end
    end
  end

  // Registers; reset treats the button as already held so a hold across
  // reset never produces a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
      rpt_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
      rpt_q   <= rpt_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/watch_cu.sv
// ============================================================================
// Module      : watch_cu
// Description : Watch set-mode control unit. The mode button steps through
//               RUN / SET_HOUR / SET_MIN / SET_SEC; in a set state the up
//               button emits increment pulses (with auto-repeat) to the
//               counter selected by the state.
// Options     : WATCH_CU_TIMEOUT_EN - return to RUN after TIMEOUT_CYCLES idle
//               cycles in a set state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module watch_cu
  import watch_pkg::*;
#(
  parameter int REPEAT_DELAY   = 50_000_000,
  parameter int REPEAT_PERIOD  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  output logic       o_run_sec,
  output logic       o_run_min,
  output logic       o_run_hour,
  output logic [1:0] o_set_sel
);

  state_e state_q, state_d;
  logic   rpt_clear;
  logic   rpt_pulse;

  // A mode press (or being in RUN) discards any press in progress, so a
  // mode change always wins over a coinciding edge or repeat.
  assign rpt_clear = i_btn_mode | (state_q == RUN);

  btn_repeat #(
    .DELAY  (REPEAT_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_btn_repeat (
    .clk   (clk),
    .rst   (rst),
    .clear (rpt_clear),
    .level (i_btn_up),
    .pulse (rpt_pulse)
  );

`ifdef WATCH_CU_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] idle_q, idle_d;
  logic            timeout;

  // Count consecutive idle cycles in a set state; any activity restarts it.
  always_comb begin
    idle_d  = '0;
    timeout = 1'b0;
    if (state_q != RUN && !i_btn_mode && !i_btn_up) begin
      if (idle_q == TO_LAST) begin
        timeout = 1'b1;
      end else begin
        idle_d = idle_q + TO_ONE;
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  // No timeout hardware in this build; the parameter only has to be sane.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_invalid
  end
`endif

  // Next state: mode press advances; optional idle timeout falls back to RUN.
  always_comb begin
    state_d = state_q;
    if (i_btn_mode) begin
      state_d = next_mode(state_q);
    end
`ifdef WATCH_CU_TIMEOUT_EN
    else if (timeout) begin
      state_d = RUN;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // The pulse was generated under the same state that is registered now,
  // so routing by state_q keeps the outputs one-hot and state-matched.
  assign o_set_sel  = state_q;
  assign o_run_hour = rpt_pulse & (state_q == SET_HOUR);
  assign o_run_min  = rpt_pulse & (state_q == SET_MIN);
  assign o_run_sec  = rpt_pulse & (state_q == SET_SEC);

endmodule

`default_nettype wire

// File: tb/tb_watch_cu.sv
// ============================================================================
// Module      : tb_watch_cu
// Description : Self-checking bench for watch_cu (REPEAT_DELAY=5,
//               REPEAT_PERIOD=3, TIMEOUT_CYCLES=20). Define
//               WATCH_CU_TIMEOUT_EN for both DUT and bench to cover the
//               timeout build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_watch_cu;

  localparam int D  = 5;
  localparam int P  = 3;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_btn_mode = 1'b0;
  logic       i_btn_up = 1'b0;
  logic       o_run_sec, o_run_min, o_run_hour;
  logic [1:0] o_set_sel;

  int checks = 0;
  int errors = 0;

  watch_cu #(
    .REPEAT_DELAY   (D),
    .REPEAT_PERIOD  (P),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_btn_mode (i_btn_mode),
    .i_btn_up   (i_btn_up),
    .o_run_sec  (o_run_sec),
    .o_run_min  (o_run_min),
    .o_run_hour (o_run_hour),
    .o_set_sel  (o_set_sel)
  );

  always #5 clk = ~clk;

  // Reference model state: plain integers and tick timestamps.
  int         tick_no = 0;
  int         m_st = 0;          // 0 run, 1 hour, 2 min, 3 sec
  bit         m_prev = 1'b1;
  bit         m_armed = 1'b0;
  int         m_press = 0;       // tick of the accepted press
  int         m_last_act = 0;    // last tick with activity (timeout model)
  logic [1:0] e_sel;
  logic [2:0] e_run;             // {hour, min, sec}
  logic [1:0] obs_sel;
  logic [2:0] obs_run;

  typedef struct {
    bit         m;
    bit         u;
    logic [1:0] sel;
    logic [2:0] run;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit m, bit u, logic [1:0] sel, logic [2:0] run);
    vec_t v;
    v.m = m; v.u = u; v.sel = sel; v.run = run;
    return v;
  endfunction

  function automatic logic [2:0] onehot(int st);
    case (st)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs after this tick: pulse on press, then at D ticks after
  // the press, then every P ticks, while held in one set state.
  task automatic model_step(input bit r, input bit m, input bit u);
    bit fire;
    int n;
    fire = 1'b0;
    if (r) begin
      m_st = 0; m_prev = 1'b1; m_armed = 1'b0; m_last_act = tick_no;
      e_sel = 2'b00; e_run = 3'b000;
      return;
    end
    if (m || m_st == 0 || !u) begin
      m_armed = 1'b0;
    end else if (!m_prev) begin
      m_armed = 1'b1; m_press = tick_no; fire = 1'b1;
    end else if (m_armed) begin
      n = tick_no - m_press;
      if (n == D || (n > D && (n - D) % P == 0)) fire = 1'b1;
    end
    e_run = fire ? onehot(m_st) : 3'b000;
    if (m || u || m_st == 0) m_last_act = tick_no;
    if (m) begin
      m_st = (m_st + 1) % 4;
    end
`ifdef WATCH_CU_TIMEOUT_EN
    else if (m_st != 0 && tick_no - m_last_act >= TO) begin
      m_st = 0; m_last_act = tick_no;
    end
`endif
    m_prev = u;
    e_sel = 2'(m_st);
  endtask

  // Drive one cycle of inputs, clock it, then sample the outputs.
  task automatic tick(input bit r, input bit m, input bit u);
    rst = r; i_btn_mode = m; i_btn_up = u;
    @(posedge clk);
    #1;
    model_step(r, m, u);
    obs_sel = o_set_sel;
    obs_run = {o_run_hour, o_run_min, o_run_sec};
    tick_no++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    chk({name, "_sel"}, 32'(obs_sel), 32'(e_sel));
    chk({name, "_run"}, 32'(obs_run), 32'(e_run));
  endtask

  initial begin
    logic [31:0] mask;
    int          bad;

    // Reset state.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    chk("reset_sel", 32'(obs_sel), 32'd0);
    chk("reset_run", 32'(obs_run), 32'd0);

    // Table: mode walk, up ignored in RUN, presses and mode/edge collision.
    tbl.push_back(mk(1, 0, 2'd1, 3'b000));
    tbl.push_back(mk(0, 0, 2'd1, 3'b000));
    tbl.push_back(mk(1, 0, 2'd2, 3'b000));
    tbl.push_back(mk(0, 0, 2'd2, 3'b000));
    tbl.push_back(mk(1, 0, 2'd3, 3'b000));
    tbl.push_back(mk(0, 0, 2'd3, 3'b000));
    tbl.push_back(mk(1, 0, 2'd0, 3'b000));
    tbl.push_back(mk(0, 0, 2'd0, 3'b000));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 1, 2'd0, 3'b000));
    tbl.push_back(mk(0, 0, 2'd0, 3'b000));
    tbl.push_back(mk(1, 0, 2'd1, 3'b000));
    tbl.push_back(mk(0, 1, 2'd1, 3'b100));
    tbl.push_back(mk(0, 1, 2'd1, 3'b000));
    tbl.push_back(mk(0, 0, 2'd1, 3'b000));
    tbl.push_back(mk(0, 1, 2'd1, 3'b100));
    tbl.push_back(mk(0, 0, 2'd1, 3'b000));
    tbl.push_back(mk(1, 0, 2'd2, 3'b000));
    tbl.push_back(mk(0, 1, 2'd2, 3'b010));
    tbl.push_back(mk(1, 1, 2'd3, 3'b000));
    tbl.push_back(mk(0, 1, 2'd3, 3'b000));
    tbl.push_back(mk(0, 0, 2'd3, 3'b000));
    tbl.push_back(mk(0, 1, 2'd3, 3'b001));
    tbl.push_back(mk(0, 0, 2'd3, 3'b000));
    tbl.push_back(mk(1, 0, 2'd0, 3'b000));
    foreach (tbl[i]) begin
      tick(1'b0, tbl[i].m, tbl[i].u);
      chk($sformatf("tbl%0d_sel", i), 32'(obs_sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_run", i), 32'(obs_run), 32'(tbl[i].run));
    end

    // Hold up 15 cycles in SET_MIN: pulses at 0,5,8,11,14 after the press.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    mask = '0;
    bad  = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1'b0, 1'b0, t < 15);
      if (obs_run[1]) mask[t] = 1'b1;
      if (obs_run[2] || obs_run[0]) bad++;
    end
    chk("hold_min_pulses", mask, 32'h0000_4921);
    chk("hold_min_other", 32'(bad), 32'd0);

    // Mode coincides with the up edge in SET_HOUR; held button stays silent.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    chk("collide_sel", 32'(obs_sel), 32'd2);
    chk("collide_run", 32'(obs_run), 32'd0);
    bad = 0;
    for (int t = 0; t < 8; t++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (obs_run != 3'b000) bad++;
    end
    chk("collide_held_pulses", 32'(bad), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("repress_run", 32'(obs_run), 32'b010);

    // Reset mid-hold in SET_SEC at repeat count 4.
    tick(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b1);
    chk("sec_press_run", 32'(obs_run), 32'b001);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    chk("midhold_rst_sel", 32'(obs_sel), 32'd0);
    chk("midhold_rst_run", 32'(obs_run), 32'd0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (obs_run != 3'b000 || obs_sel != 2'd0) bad++;
    end
    chk("after_rst_quiet", 32'(bad), 32'd0);

`ifdef WATCH_CU_TIMEOUT_EN
    // Idle timeout: back to RUN exactly TO cycles after entering SET_HOUR.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (k == TO - 1) chk("to_before_sel", 32'(obs_sel), 32'd1);
      if (k == TO)     chk("to_expire_sel", 32'(obs_sel), 32'd0);
    end
    // An up press at idle cycle 15 restarts the count.
    tick(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 35; k++) begin
      tick(1'b0, 1'b0, k == 15);
      if (k == 15) chk("to_press_run", 32'(obs_run), 32'b100);
      if (k == 34) chk("to_restart_hold_sel", 32'(obs_sel), 32'd1);
      if (k == 35) chk("to_restart_expire_sel", 32'(obs_sel), 32'd0);
    end
`else
    // Without the timeout option a set state persists indefinitely.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    bad = 0;
    for (int k = 0; k < 3 * TO; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (obs_sel != 2'd1) bad++;
    end
    chk("no_timeout_persist", 32'(bad), 32'd0);
`endif

    // Randomized traffic against the model.
    tick(1'b1, 1'b0, 1'b0);
    begin
      bit u;
      u = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 11) == 0) u = ~u;
        tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, u);
        chk_model($sformatf("rnd%0d", k));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/watch_cu.md
WATCH_CU -- requirements
Module: watch_cu

Interface
REQ-001 Parameter REPEAT_DELAY, default 50_000_000: clk cycles a held up-button waits before its first auto-repeat pulse.
REQ-002 Parameter REPEAT_PERIOD, default 10_000_000: clk cycles between successive auto-repeat pulses after the first.
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000_000: idle clk cycles in a set state before the block returns to RUN (used only with WATCH_CU_TIMEOUT_EN).
REQ-004 Port clk  input  1  system clock; the single clock for all state.
REQ-005 Port rst  input  1  reset, synchronous to clk and active-high.
REQ-006 Port i_btn_mode  input  1  debounced single-cycle pulse that advances the set mode.
REQ-007 Port i_btn_up  input  1  debounced level, high while the up button is held.
REQ-008 Port o_run_sec  output  1  single-cycle increment pulse to the seconds counter.
REQ-009 Port o_run_min  output  1  single-cycle increment pulse to the minutes counter.
REQ-010 Port o_run_hour  output  1  single-cycle increment pulse to the hours counter.
REQ-011 Port o_set_sel  output  2  current state encoding, used by the display for blink selection.

Function
REQ-012 The FSM SHALL have states RUN=2'b00, SET_HOUR=2'b01, SET_MIN=2'b10 and SET_SEC=2'b11, and o_set_sel SHALL equal the registered state.
REQ-013 Each i_btn_mode pulse SHALL advance the state RUN->SET_HOUR->SET_MIN->SET_SEC->RUN, one step per pulse, taking effect on the next clk edge.
REQ-014 In RUN, i_btn_up SHALL be ignored and all o_run_* SHALL stay 0.
REQ-015 In SET_x, a 0->1 transition of i_btn_up SHALL produce exactly one o_run_x pulse in the cycle after the edge (1-cycle latency, registered output).
REQ-016 While i_btn_up stays high in the same SET_x state, further o_run_x pulses SHALL occur REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles.
REQ-017 Releasing i_btn_up SHALL clear the repeat timer immediately, with no further pulses.
REQ-018 At most one o_run_* output SHALL be high in any cycle, and it SHALL match the current set state.
REQ-019 If i_btn_mode and a new up-edge (or repeat expiry) coincide, the mode change SHALL win, no pulse SHALL be emitted that cycle, and the repeat timer SHALL clear.
REQ-020 If i_btn_up is still held when entering a new SET state, no pulse SHALL occur until i_btn_up is released and pressed again.
REQ-021 Repeat and timeout counters SHALL be $clog2(param+1) bits wide, SHALL saturate/clear rather than wrap, and REPEAT_DELAY/REPEAT_PERIOD >= 1.

Reset
REQ-022 On rst high at a clk edge: state=RUN, o_set_sel=2'b00, all o_run_*=0, all counters=0, and the up-edge detector SHALL treat i_btn_up as previously high; reset mid-hold SHALL emit no pulse.

Configuration
REQ-023 With WATCH_CU_TIMEOUT_EN defined, TIMEOUT_CYCLES consecutive cycles in a SET state with i_btn_mode=0 and i_btn_up=0 SHALL return the state to RUN on the next edge; any activity SHALL clear the counter.
REQ-024 Without WATCH_CU_TIMEOUT_EN, no timeout logic SHALL exist, and set states persist until i_btn_mode.

Structure
REQ-025 State encoding constants (RUN, SET_HOUR, SET_MIN, SET_SEC) SHALL live in shared package watch_pkg for reuse by the display logic.
REQ-026 Edge detection plus delay/period counting SHALL be a sub-module btn_repeat (inputs clk, rst, clear, level; output pulse), instantiated once.

Verification (REPEAT_DELAY=5, REPEAT_PERIOD=3, TIMEOUT_CYCLES=20)
REQ-027 Reset, then 4 mode pulses spaced 2 cycles apart -> o_set_sel reads 01,10,11,00; no o_run_* pulses.
REQ-028 In SET_MIN, hold up for 15 cycles starting at t=0 -> o_run_min high at t=1, 6, 9, 12, 15 only; o_run_sec and o_run_hour stay 0.
REQ-029 In RUN, hold up for 10 cycles -> no o_run_* pulses.
REQ-030 In SET_HOUR, mode pulse in the same cycle as the up-edge -> state becomes SET_MIN, no pulse; holding up afterwards gives no pulse until release and re-press.
REQ-031 Assert rst mid-hold in SET_SEC at repeat count 4 -> state RUN next cycle, no o_run_sec pulse at the would-be repeat cycle.
REQ-032 With WATCH_CU_TIMEOUT_EN, enter SET_HOUR and stay idle -> o_set_sel returns to 00 exactly 20 cycles later; an up-press at cycle 15 restarts the 20-cycle count.
